// File: rtl/rhythm_scheduler_pkg.sv
// Shared definitions for the gamma/theta/delta rhythm scheduler:
// FSM state codes, parameter legal ranges and the index width.
package rhythm_scheduler_pkg;

    localparam int unsigned IDX_W = 3;

    localparam int unsigned GAMMA_PERIOD_MIN    = 4;
    localparam int unsigned GAMMA_PERIOD_MAX    = 255;
    localparam int unsigned GAMMA_PER_THETA_MIN = 2;
    localparam int unsigned GAMMA_PER_THETA_MAX = 8;
    localparam int unsigned THETA_PER_DELTA_MIN = 2;
    localparam int unsigned THETA_PER_DELTA_MAX = 7;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_RUN      = 2'd1;
    localparam state_t ST_PAUSED   = 2'd2;
    localparam state_t ST_STOPPING = 2'd3;

endpackage

// File: rtl/rhythm_divider.sv
// Phase divider: counts 0..PERIOD-1 while enabled and emits a registered
// one-cycle pulse on the wrap back to 0; clear forces the phase to 0.
module rhythm_divider #(
    parameter int unsigned PERIOD = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    localparam int unsigned CNT_W = $clog2(PERIOD);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == CNT_W'(PERIOD - 1)) begin
                cnt_d  = '0;
                wrap_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;

endmodule

// File: rtl/rhythm_scheduler.sv
// Nested rhythm generator: gamma ticks from a phase divider, theta and delta
// ticks chained one clock behind their trigger, under a run/pause/stop FSM.
module rhythm_scheduler
    import rhythm_scheduler_pkg::*;
#(
    parameter int unsigned GAMMA_PERIOD    = 16,
    parameter int unsigned GAMMA_PER_THETA = 8,
    parameter int unsigned THETA_PER_DELTA = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             stop_req,
    input  logic             abort,
    output logic             gamma_tick,
    output logic             theta_tick,
    output logic             delta_tick,
    output logic [IDX_W-1:0] gamma_idx,
    output logic [IDX_W-1:0] theta_idx,
    output logic [7:0]       delta_count,
    output logic             running,
    output logic             done
);

    if (GAMMA_PERIOD < GAMMA_PERIOD_MIN || GAMMA_PERIOD > GAMMA_PERIOD_MAX) begin : g_bad_gamma_period
        $error("rhythm_scheduler: GAMMA_PERIOD out of range");
    end
    if (GAMMA_PER_THETA < GAMMA_PER_THETA_MIN || GAMMA_PER_THETA > GAMMA_PER_THETA_MAX) begin : g_bad_gamma_per_theta
        $error("rhythm_scheduler: GAMMA_PER_THETA out of range");
    end
    if (THETA_PER_DELTA < THETA_PER_DELTA_MIN || THETA_PER_DELTA > THETA_PER_DELTA_MAX) begin : g_bad_theta_per_delta
        $error("rhythm_scheduler: THETA_PER_DELTA out of range");
    end

    state_t           state_q, state_d;
    logic [IDX_W-1:0] gamma_idx_q, gamma_idx_d;
    logic [IDX_W-1:0] theta_idx_q, theta_idx_d;
    logic [7:0]       delta_count_q, delta_count_d;
    logic             theta_tick_q, theta_tick_d;
    logic             delta_tick_q, delta_tick_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic             div_en, div_clr, gamma_wrap;

    rhythm_divider #(
        .PERIOD (GAMMA_PERIOD)
    ) u_divider (
        .clk  (clk),
        .rst  (rst),
        .en   (div_en),
        .clr  (div_clr),
        .wrap (gamma_wrap)
    );

    always_comb begin
        state_d       = state_q;
        gamma_idx_d   = gamma_idx_q;
        theta_idx_d   = theta_idx_q;
        delta_count_d = delta_count_q;
        theta_tick_d  = 1'b0;
        delta_tick_d  = 1'b0;
        done_d        = 1'b0;

        case (state_q)
            ST_IDLE:     if (start && !abort) state_d = ST_RUN;
            ST_RUN: begin
                if (stop_req)   state_d = ST_STOPPING;
                else if (pause) state_d = ST_PAUSED;
            end
            ST_PAUSED: begin
                if (stop_req)    state_d = ST_STOPPING;
                else if (!pause) state_d = ST_RUN;
            end
            ST_STOPPING: begin
                if (delta_tick_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default:     state_d = ST_IDLE;
        endcase

        // Chained ticks run regardless of pause so a triggered tick is never lost.
        if (gamma_wrap) begin
            if (gamma_idx_q == IDX_W'(GAMMA_PER_THETA - 1)) begin
                gamma_idx_d  = '0;
                theta_tick_d = 1'b1;
            end else begin
                gamma_idx_d = gamma_idx_q + IDX_W'(1);
            end
        end
        if (theta_tick_q) begin
            if (theta_idx_q == IDX_W'(THETA_PER_DELTA - 1)) begin
                theta_idx_d   = '0;
                delta_tick_d  = 1'b1;
                delta_count_d = delta_count_q + 8'd1;
            end else begin
                theta_idx_d = theta_idx_q + IDX_W'(1);
            end
        end

        if (state_q == ST_IDLE && state_d == ST_RUN) delta_count_d = '0;

        if (abort && state_q != ST_IDLE) begin
            state_d       = ST_IDLE;
            gamma_idx_d   = '0;
            theta_idx_d   = '0;
            delta_count_d = '0;
            theta_tick_d  = 1'b0;
            delta_tick_d  = 1'b0;
            done_d        = 1'b1;
        end

        running_d = (state_d != ST_IDLE);
        // Phase advances only on edges that stay in a counting state, so a pause
        // of N cycles shifts every later tick by exactly N.
        div_en  = (state_q != ST_IDLE) && (state_d == ST_RUN || state_d == ST_STOPPING);
        div_clr = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            gamma_idx_q   <= '0;
            theta_idx_q   <= '0;
            delta_count_q <= '0;
            theta_tick_q  <= 1'b0;
            delta_tick_q  <= 1'b0;
            running_q     <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            gamma_idx_q   <= gamma_idx_d;
            theta_idx_q   <= theta_idx_d;
            delta_count_q <= delta_count_d;
            theta_tick_q  <= theta_tick_d;
            delta_tick_q  <= delta_tick_d;
            running_q     <= running_d;
            done_q        <= done_d;
        end
    end

    assign gamma_tick  = gamma_wrap;
    assign theta_tick  = theta_tick_q;
    assign delta_tick  = delta_tick_q;
    assign gamma_idx   = gamma_idx_q;
    assign theta_idx   = theta_idx_q;
    assign delta_count = delta_count_q;
    assign running     = running_q;
    assign done        = done_q;

endmodule
